seq_divider: RTL and testbench

- Parametrised iterative restoring divider; next generation of the 32-bit divide unit.
- Produces one quotient bit per cycle. Returns both quotient and remainder.
- Runtime signed/unsigned mode, explicit start/busy handshake, divide-by-zero fast path.
- Sits beside the multiplier in the CPU execute stage. The pipeline stalls on busy.

---
 rtl/div_pkg.sv | 22 ++
 rtl/cond_negate.sv | 20 ++
 rtl/seq_divider.sv | 178 +++++++++++++++++
 tb/tb_seq_divider.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and constants for the sequential divider
// Contents:
//    state_t      divider control states
//    SIGNED       signed_mode value selecting two's-complement operands
//    UNSIGNED     signed_mode value selecting raw unsigned operands
//    cnt_width()  iteration counter width for a given operand width
package div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic SIGNED   = 1'b1;
   localparam logic UNSIGNED = 1'b0;

   function automatic int cnt_width(input int width);
      return $clog2(width) + 1;
   endfunction

endpackage

// File: rtl/cond_negate.sv
// rtl/cond_negate.sv - conditional two's-complement negation
// Ports:
//    data_in   WIDTH  value to pass or negate
//    neg       1      1 = output -data_in, 0 = output data_in
//    data_out  WIDTH  result
module cond_negate #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] data_in,
   input  logic             neg,
   output logic [WIDTH-1:0] data_out
);

   // Negation is invert-plus-one, i.e. the adder with its B operand tied to 1.
   logic [WIDTH-1:0] inc_sum;

   assign inc_sum  = ~data_in + WIDTH'(1);
   assign data_out = neg ? inc_sum : data_in;

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - iterative restoring divider, one quotient bit per cycle
// Optional build macro: DIV_EARLY_EXIT_EN (skip CALC when |A| < |B|)
// Ports:
//    clk             rising-edge clock
//    rst             asynchronous active-low reset
//    start           request, accepted only in IDLE
//    signed_mode     1 = two's-complement operands, sampled with start
//    data_operandA   dividend, sampled with start
//    data_operandB   divisor, sampled with start
//    busy            high from the cycle after accept until DONE completes
//    data_result     quotient, registered
//    data_remainder  remainder, registered
//    data_resultRDY  one-cycle pulse, results valid
//    data_exception  divide-by-zero flag, updated with the results
module seq_divider
   import div_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             signed_mode,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   output logic             busy,
   output logic [WIDTH-1:0] data_result,
   output logic [WIDTH-1:0] data_remainder,
   output logic             data_resultRDY,
   output logic             data_exception
);

   localparam int CNT_W = cnt_width(WIDTH);

   state_t             state;
   state_t             state_nxt;
   logic [CNT_W-1:0]   count;
   logic [WIDTH-1:0]   rem_q;
   logic [WIDTH-1:0]   quo_q;
   logic [WIDTH-1:0]   abs_b_q;
   logic               neg_quo_q;
   logic               neg_rem_q;
   logic               div_zero_q;

   logic               op_neg_a;
   logic               op_neg_b;
   logic [WIDTH-1:0]   abs_a;
   logic [WIDTH-1:0]   abs_b;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;
   logic [WIDTH:0]     rem_sh;
   logic [WIDTH:0]     trial;
   logic               div_zero;
   logic               early;
   logic               calc_last;

   assign op_neg_a = (signed_mode == SIGNED) && data_operandA[WIDTH-1];
   assign op_neg_b = (signed_mode == SIGNED) && data_operandB[WIDTH-1];
   assign div_zero = (data_operandB == '0);

   cond_negate #(.WIDTH(WIDTH)) u_abs_a (
      .data_in  (data_operandA),
      .neg      (op_neg_a),
      .data_out (abs_a)
   );

   cond_negate #(.WIDTH(WIDTH)) u_abs_b (
      .data_in  (data_operandB),
      .neg      (op_neg_b),
      .data_out (abs_b)
   );

   cond_negate #(.WIDTH(WIDTH)) u_fix_quo (
      .data_in  (quo_q),
      .neg      (neg_quo_q),
      .data_out (quo_fix)
   );

   cond_negate #(.WIDTH(WIDTH)) u_fix_rem (
      .data_in  (rem_q),
      .neg      (neg_rem_q),
      .data_out (rem_fix)
   );

`ifdef DIV_EARLY_EXIT_EN
   // Magnitude of A below magnitude of B: quotient is 0, remainder is A itself.
   assign early = !div_zero && (abs_a < abs_b);
`else
   assign early = 1'b0;
`endif

   // The partial remainder always stays below |B|, so after the shift it is
   // below 2*|B|; bit WIDTH of the WIDTH+1-bit difference is then a true sign.
   assign rem_sh    = {rem_q, quo_q[WIDTH-1]};
   assign trial     = rem_sh - {1'b0, abs_b_q};
   assign calc_last = (count == CNT_W'(WIDTH - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_nxt = (div_zero || early) ? DONE : CALC;
            end
         end
         CALC: begin
            if (calc_last) begin
               state_nxt = DONE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Results are registered on the DONE exit edge, so resultRDY appears in the
   // following IDLE cycle, the same cycle busy drops and a new start is taken.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count          <= '0;
         rem_q          <= '0;
         quo_q          <= '0;
         abs_b_q        <= '0;
         neg_quo_q      <= 1'b0;
         neg_rem_q      <= 1'b0;
         div_zero_q     <= 1'b0;
         busy           <= 1'b0;
         data_result    <= '0;
         data_remainder <= '0;
         data_resultRDY <= 1'b0;
         data_exception <= 1'b0;
      end else begin
         data_resultRDY <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  busy       <= 1'b1;
                  count      <= '0;
                  abs_b_q    <= abs_b;
                  neg_quo_q  <= op_neg_a ^ op_neg_b;
                  neg_rem_q  <= op_neg_a;
                  div_zero_q <= div_zero;
                  rem_q      <= early ? abs_a : '0;
                  quo_q      <= early ? '0 : abs_a;
               end
            end
            CALC: begin
               rem_q <= trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
               quo_q <= {quo_q[WIDTH-2:0], ~trial[WIDTH]};
               count <= count + CNT_W'(1);
            end
            DONE: begin
               busy           <= 1'b0;
               data_resultRDY <= 1'b1;
               if (div_zero_q) begin
                  data_result    <= '0;
                  data_remainder <= '0;
                  data_exception <= 1'b1;
               end else begin
                  data_result    <= quo_fix;
                  data_remainder <= rem_fix;
                  data_exception <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - directed and randomised bench for seq_divider
module tb_seq_divider;
   import div_pkg::*;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          signed_mode;
   logic [W-1:0]  data_operandA;
   logic [W-1:0]  data_operandB;
   logic          busy;
   logic [W-1:0]  data_result;
   logic [W-1:0]  data_remainder;
   logic          data_resultRDY;
   logic          data_exception;

   typedef struct {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         e;
      int           lat;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   passed = 0;

   seq_divider #(.WIDTH(W)) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .signed_mode    (signed_mode),
      .data_operandA  (data_operandA),
      .data_operandB  (data_operandB),
      .busy           (busy),
      .data_result    (data_result),
      .data_remainder (data_remainder),
      .data_resultRDY (data_resultRDY),
      .data_exception (data_exception)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
   endtask

   function automatic logic [W-1:0] mag(input logic [W-1:0] v, input logic neg);
      return neg ? (~v + 1) : v;
   endfunction

   function automatic int exp_lat(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
      if (b == '0) return 1;
`ifdef DIV_EARLY_EXIT_EN
      if (mag(a, sgn & a[W-1]) < mag(b, sgn & b[W-1])) return 1;
`endif
      return W + 1;
   endfunction

   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
      exp_t       x;
      logic       na;
      logic       nb;
      logic [W-1:0] ma;
      logic [W-1:0] mb;
      na = sgn & a[W-1];
      nb = sgn & b[W-1];
      ma = mag(a, na);
      mb = mag(b, nb);
      x.lat = exp_lat(a, b, sgn);
      if (b == '0) begin
         x.q = '0;
         x.r = '0;
         x.e = 1'b1;
      end else begin
         x.q = mag(ma / mb, na ^ nb);
         x.r = mag(ma % mb, na);
         x.e = 1'b0;
      end
      return x;
   endfunction

   function automatic exp_t lit(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                                input logic [W-1:0] q, input logic [W-1:0] r, input logic e);
      exp_t x;
      x.q   = q;
      x.r   = r;
      x.e   = e;
      x.lat = exp_lat(a, b, sgn);
      return x;
   endfunction

   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn);
      data_operandA = a;
      data_operandB = b;
      signed_mode   = sgn;
      start         = 1'b1;
      @(posedge clk);
      #1;
      start         = 1'b0;
      data_operandA = $urandom;
      data_operandB = $urandom;
      signed_mode   = ~sgn;
      check("busy_after_accept", {31'd0, busy}, 32'd1);
   endtask

   task automatic wait_result(input string tag, input int pulse_at,
                              input logic [W-1:0] pa, input logic [W-1:0] pb);
      int   n    = 0;
      bit   seen = 0;
      exp_t x;
      while (!seen && n < 60) begin
         @(posedge clk);
         #1;
         n++;
         start = 1'b0;
         if (data_resultRDY) seen = 1;
         else if (n == pulse_at) begin
            start         = 1'b1;
            data_operandA = pa;
            data_operandB = pb;
         end
      end
      check({tag, "_rdy_seen"}, {31'd0, seen}, 32'd1);
      if (seen && sb.size() > 0) begin
         x = sb.pop_front();
         check({tag, "_latency"}, n, x.lat);
         check({tag, "_quotient"}, data_result, x.q);
         check({tag, "_remainder"}, data_remainder, x.r);
         check({tag, "_exception"}, {31'd0, data_exception}, {31'd0, x.e});
         check({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
      end
   endtask

   task automatic count_rdy(input int cycles, output int cnt);
      cnt = 0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         #1;
         if (data_resultRDY) cnt++;
      end
   endtask

   initial begin
      int          extra;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic        rs;

      rst           = 1'b0;
      start         = 1'b0;
      signed_mode   = UNSIGNED;
      data_operandA = '0;
      data_operandB = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
      check("reset_quotient", data_result, 32'd0);
      check("reset_remainder", data_remainder, 32'd0);
      check("reset_exception", {31'd0, data_exception}, 32'd0);
      rst = 1'b1;
      @(posedge clk);
      #1;

      sb.push_back(lit(32'd100, 32'd7, UNSIGNED, 32'd14, 32'd2, 1'b0));
      issue(32'd100, 32'd7, UNSIGNED);
      wait_result("u100_7", 0, '0, '0);

      sb.push_back(lit(32'hFFFFFF9C, 32'd7, SIGNED, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0));
      issue(32'hFFFFFF9C, 32'd7, SIGNED);
      wait_result("s_m100_7", 0, '0, '0);

      sb.push_back(lit(32'd100, 32'hFFFFFFF9, SIGNED, 32'hFFFFFFF2, 32'd2, 1'b0));
      issue(32'd100, 32'hFFFFFFF9, SIGNED);
      wait_result("s_100_m7", 0, '0, '0);

      sb.push_back(lit(32'd5, 32'd0, UNSIGNED, 32'd0, 32'd0, 1'b1));
      issue(32'd5, 32'd0, UNSIGNED);
      wait_result("div_zero", 0, '0, '0);

      sb.push_back(lit(32'd9, 32'd3, UNSIGNED, 32'd3, 32'd0, 1'b0));
      issue(32'd9, 32'd3, UNSIGNED);
      wait_result("after_dz", 0, '0, '0);

      sb.push_back(lit(32'h80000000, 32'hFFFFFFFF, SIGNED, 32'h80000000, 32'd0, 1'b0));
      issue(32'h80000000, 32'hFFFFFFFF, SIGNED);
      wait_result("min_m1", 0, '0, '0);

      sb.push_back(lit(32'd1000, 32'd9, UNSIGNED, 32'd111, 32'd1, 1'b0));
      issue(32'd1000, 32'd9, UNSIGNED);
      wait_result("start_busy", 10, 32'd77, 32'd5);
      count_rdy(40, extra);
      check("start_busy_extra_rdy", extra, 0);

      sb.push_back(lit(32'd3, 32'd10, UNSIGNED, 32'd0, 32'd3, 1'b0));
      issue(32'd3, 32'd10, UNSIGNED);
      wait_result("small_over_big", 0, '0, '0);

      sb.push_back(lit(32'hFFFFFFF9, 32'd100, SIGNED, 32'd0, 32'hFFFFFFF9, 1'b0));
      issue(32'hFFFFFFF9, 32'd100, SIGNED);
      wait_result("s_m7_100", 0, '0, '0);

      sb.push_back(lit(32'hFFFFFFFF, 32'd1, UNSIGNED, 32'hFFFFFFFF, 32'd0, 1'b0));
      issue(32'hFFFFFFFF, 32'd1, UNSIGNED);
      wait_result("u_max_1", 0, '0, '0);

      // Start during DONE is dropped, start in the following IDLE is taken.
      sb.push_back(lit(32'd50, 32'd6, UNSIGNED, 32'd8, 32'd2, 1'b0));
      issue(32'd50, 32'd6, UNSIGNED);
      wait_result("done_start", W, 32'd11, 32'd2);
      sb.push_back(lit(32'hFFFFFFFF, 32'hFFFFFFFF, UNSIGNED, 32'd1, 32'd0, 1'b0));
      issue(32'hFFFFFFFF, 32'hFFFFFFFF, UNSIGNED);
      wait_result("back_to_back", 0, '0, '0);

      for (int i = 0; i < 6; i++) begin
         ra = $urandom;
         rb = $urandom >> $urandom_range(0, 28);
         rs = logic'(i & 1);
         sb.push_back(model(ra, rb, rs));
         issue(ra, rb, rs);
         wait_result("random", 0, '0, '0);
      end

      // Abort mid-CALC with asynchronous reset.
      issue(32'hDEADBEEF, 32'h1234, UNSIGNED);
      repeat (15) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_rdy", {31'd0, data_resultRDY}, 32'd0);
      check("abort_quotient", data_result, 32'd0);
      check("abort_remainder", data_remainder, 32'd0);
      check("abort_exception", {31'd0, data_exception}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      count_rdy(50, extra);
      check("abort_no_rdy", extra, 0);

      sb.push_back(lit(32'd123456, 32'd789, UNSIGNED, 32'd156, 32'd372, 1'b0));
      issue(32'd123456, 32'd789, UNSIGNED);
      wait_result("after_abort", 0, '0, '0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
